// File: rtl/lock_input_conditioner_pkg.sv
// Shared definitions for the lock input conditioner and the lock controller
// that consumes its sw_pulse vector.
//   N_CH            number of operator switch channels
//   CH_*            bit index of each switch inside raw_sw / sw_level / sw_pulse
//   CONFLICT_PAIRS  masks of channel pairs whose simultaneous rising pulses
//                   contradict each other and are both dropped
//   pair_hit()      true when every channel of a pair mask pulses together
package lock_input_conditioner_pkg;

  localparam int N_CH = 6;

  localparam int CH_INC        = 0;
  localparam int CH_DEC        = 1;
  localparam int CH_INNER_DOOR = 2;
  localparam int CH_OUTER_DOOR = 3;
  localparam int CH_OUTER_ARR  = 4;
  localparam int CH_INNER_ARR  = 5;

  typedef logic [N_CH-1:0] ch_vec_t;

  // Fill vs drain, and the two gondola arrival sensors.
  localparam ch_vec_t PAIR_A_MASK = ch_vec_t'((1 << CH_INC) | (1 << CH_DEC));
  localparam ch_vec_t PAIR_B_MASK = ch_vec_t'((1 << CH_OUTER_ARR) | (1 << CH_INNER_ARR));

  localparam int N_PAIRS = 2;
  localparam logic [N_PAIRS-1:0][N_CH-1:0] CONFLICT_PAIRS = {PAIR_B_MASK, PAIR_A_MASK};

  function automatic logic pair_hit(input ch_vec_t rp, input ch_vec_t mask);
    return (rp & mask) == mask;
  endfunction

endpackage

// File: rtl/lock_input_conditioner_if.sv
// Signal bundle between the operator switch panel side and the conditioner.
//   raw_sw         raw asynchronous switches (panel -> conditioner)
//   sw_level       debounced level per channel
//   sw_pulse       one-cycle pulse per accepted rising edge, conflict filtered
//   tick           one-cycle time-base pulse
//   conflict       one-cycle pulse when a contradictory pair was suppressed
//   conflict_seen  sticky conflict flag, cleared only by reset
// Handshake: there is no valid/ready; every output is either a level that is
// valid every cycle or a single-cycle pulse that the consumer must sample on
// the clock edge it is high, with no backpressure possible.
interface lock_input_conditioner_if;
  import lock_input_conditioner_pkg::*;

  ch_vec_t raw_sw;
  ch_vec_t sw_level;
  ch_vec_t sw_pulse;
  logic    tick;
  logic    conflict;
  logic    conflict_seen;

  modport master (
    output raw_sw,
    input  sw_level, sw_pulse, tick, conflict, conflict_seen
  );

  modport slave (
    input  raw_sw,
    output sw_level, sw_pulse, tick, conflict, conflict_seen
  );

endinterface

// File: rtl/lock_input_conditioner_debounce_channel.sv
// One switch channel: two-flop synchroniser, debounce counter and stable level.
//   clk    system clock
//   reset  asynchronous active-low reset
//   raw    raw asynchronous switch input
//   level  debounced stable level (registered)
//   rise   combinational: high in the cycle whose closing edge moves level 0->1,
//          so a registered consumer sees its pulse together with the new level
module debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;
  logic          accept;

  // The synchronised input has disagreed with level for the full window.
  assign accept = (sync_q2 != level) && (cnt_q == CNT_LAST);
  assign rise   = accept & sync_q2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt_q   <= '0;
      level   <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
      if (sync_q2 == level) begin
        // Any agreement restarts qualification, discarding short glitches.
        cnt_q <= '0;
      end else if (accept) begin
        level <= sync_q2;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lock_input_conditioner.sv
// Front end of the canal lock controller. Debounces the six operator
// switches, produces rising-edge pulses with contradictory pairs removed, and
// generates the periodic time-base tick.
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    lock_input_conditioner_if.slave: raw_sw in; sw_level, sw_pulse,
//          tick, conflict, conflict_seen out
module lock_input_conditioner
  import lock_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TICK_DIV        = 50_000_000
) (
  input logic                     clk,
  input logic                     reset,
  lock_input_conditioner_if.slave bus
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  ch_vec_t       level_w;
  ch_vec_t       rp;
  ch_vec_t       filt;
  logic          hit;
  ch_vec_t       pulse_q;
  logic          conflict_q;
  logic          seen_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .raw   (bus.raw_sw[i]),
      .level (level_w[i]),
      .rise  (rp[i])
    );
  end

  // Both members of a pair pulsing in the same cycle cancel each other. Two
  // pairs colliding at once still raise a single conflict pulse.
  always_comb begin
    filt = rp;
    hit  = 1'b0;
    for (int p = 0; p < N_PAIRS; p++) begin
      if (pair_hit(rp, CONFLICT_PAIRS[p])) begin
        filt = filt & ~ch_vec_t'(CONFLICT_PAIRS[p]);
        hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q    <= '0;
      conflict_q <= 1'b0;
      seen_q     <= 1'b0;
    end else begin
      pulse_q    <= filt;
      conflict_q <= hit;
      seen_q     <= seen_q | hit;
    end
  end

  // Free-running divider; tick is registered so it appears the cycle after
  // the counter sits at its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_q <= (tick_cnt_q == TICK_LAST);
      if (tick_cnt_q == TICK_LAST) begin
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick_cnt_q + 1'b1;
      end
    end
  end

  assign bus.sw_level      = level_w;
  assign bus.sw_pulse      = pulse_q;
  assign bus.conflict      = conflict_q;
  assign bus.conflict_seen = seen_q;
  assign bus.tick          = tick_q;

endmodule

// File: tb/tb_lock_input_conditioner.sv
// Directed bench for lock_input_conditioner with DEBOUNCE_CYCLES=4, TICK_DIV=4.
// Pulse/conflict events are predicted as {edge, sw_pulse, conflict} words
// pushed into exp_q; a negedge monitor pops one whenever the DUT shows a pulse.
module tb_lock_input_conditioner;
  import lock_input_conditioner_pkg::*;

  localparam int W = 32 + N_CH + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] edge_cnt = '0;
  int          tests = 0;
  int          fails = 0;
  logic [W-1:0] exp_q[$];

  lock_input_conditioner_if dut_if ();

  lock_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dut_if.slave)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic push_exp(input logic [31:0] cyc, input ch_vec_t pulse, input logic conf);
    exp_q.push_back({cyc, pulse, conf});
  endtask

  // Called at a negedge; returns at the negedge following edge t.
  task automatic wait_edge(input logic [31:0] t);
    while (edge_cnt < t) @(negedge clk);
  endtask

  task automatic set_sw(input ch_vec_t mask, input logic v);
    for (int i = 0; i < N_CH; i++)
      if (mask[i]) dut_if.raw_sw[i] = v;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (dut_if.sw_pulse != '0 || dut_if.conflict) begin
      logic [W-1:0] act;
      act = {edge_cnt, dut_if.sw_pulse, dut_if.conflict};
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'(act), 64'(0));
      end else begin
        check("pulse_event", 64'(act), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] e0;
    int tick_cnt;
    dut_if.raw_sw = '0;

    // Reset state
    #12;
    check("reset_level", 64'(dut_if.sw_level), 64'(0));
    check("reset_pulse", 64'(dut_if.sw_pulse), 64'(0));
    check("reset_tick", 64'(dut_if.tick), 64'(0));
    check("reset_seen", 64'(dut_if.conflict_seen), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // Tick: high after edges 4, 8, ... ; 100 edges give 25 ticks
    tick_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      check("tick_phase", 64'(dut_if.tick), 64'((i % 4) == 0));
      if (dut_if.tick) tick_cnt++;
    end
    check("tick_count", 64'(tick_cnt), 64'(25));

    // Clean press on inner door, held
    @(negedge clk);
    set_sw(6'b000100, 1'b1);
    e0 = edge_cnt + 1;
    push_exp(e0 + 5, 6'b000100, 1'b0);
    wait_edge(e0 + 4);
    check("press_level_early", 64'(dut_if.sw_level[CH_INNER_DOOR]), 64'(0));
    wait_edge(e0 + 5);
    check("press_level", 64'(dut_if.sw_level[CH_INNER_DOOR]), 64'(1));
    wait_edge(e0 + 6);
    check("press_level_held", 64'(dut_if.sw_level[CH_INNER_DOOR]), 64'(1));
    check("press_pulse_gone", 64'(dut_if.sw_pulse[CH_INNER_DOOR]), 64'(0));
    wait_edge(e0 + 16);

    // Release path on outer door: pulse on rise only
    set_sw(6'b001000, 1'b1);
    e0 = edge_cnt + 1;
    push_exp(e0 + 5, 6'b001000, 1'b0);
    wait_edge(e0 + 10);
    set_sw(6'b001000, 1'b0);
    e0 = edge_cnt + 1;
    wait_edge(e0 + 4);
    check("fall_level_early", 64'(dut_if.sw_level[CH_OUTER_DOOR]), 64'(1));
    wait_edge(e0 + 5);
    check("fall_level", 64'(dut_if.sw_level[CH_OUTER_DOOR]), 64'(0));
    wait_edge(e0 + 10);

    // Bounce on fill: 2 high, 1 low, then steady high
    set_sw(6'b000001, 1'b1);
    @(negedge clk);
    @(negedge clk);
    set_sw(6'b000001, 1'b0);
    @(negedge clk);
    set_sw(6'b000001, 1'b1);
    e0 = edge_cnt + 1;
    push_exp(e0 + 5, 6'b000001, 1'b0);
    wait_edge(e0 + 4);
    check("bounce_level_early", 64'(dut_if.sw_level[CH_INC]), 64'(0));
    wait_edge(e0 + 5);
    check("bounce_level", 64'(dut_if.sw_level[CH_INC]), 64'(1));
    wait_edge(e0 + 10);

    // Simultaneous gondola arrivals: suppressed, one conflict
    check("seen_before", 64'(dut_if.conflict_seen), 64'(0));
    set_sw(6'b110000, 1'b1);
    e0 = edge_cnt + 1;
    push_exp(e0 + 5, 6'b000000, 1'b1);
    wait_edge(e0 + 5);
    check("conf_levels", 64'(dut_if.sw_level[5:4]), 64'(2'b11));
    check("conf_seen", 64'(dut_if.conflict_seen), 64'(1));
    wait_edge(e0 + 8);
    set_sw(6'b110000, 1'b0);
    wait_edge(edge_cnt + 8);

    // Staggered by one cycle: two pulses, no conflict
    set_sw(6'b010000, 1'b1);
    e0 = edge_cnt + 1;
    push_exp(e0 + 5, 6'b010000, 1'b0);
    @(negedge clk);
    set_sw(6'b100000, 1'b1);
    push_exp(e0 + 6, 6'b100000, 1'b0);
    wait_edge(e0 + 8);
    check("stagger_levels", 64'(dut_if.sw_level[5:4]), 64'(2'b11));
    check("seen_sticky", 64'(dut_if.conflict_seen), 64'(1));

    // Both pairs collide in one cycle: single conflict pulse
    set_sw(6'b110001, 1'b0);
    wait_edge(edge_cnt + 8);
    set_sw(6'b110011, 1'b1);
    e0 = edge_cnt + 1;
    push_exp(e0 + 5, 6'b000000, 1'b1);
    wait_edge(e0 + 8);
    check("dual_levels", 64'(dut_if.sw_level), 64'(6'b110111));
    set_sw(6'b110011, 1'b0);
    wait_edge(edge_cnt + 8);

    // Async reset mid-qualification on drain
    set_sw(6'b000010, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_level", 64'(dut_if.sw_level), 64'(0));
    check("arst_pulse", 64'(dut_if.sw_pulse), 64'(0));
    check("arst_conflict", 64'(dut_if.conflict), 64'(0));
    check("arst_seen", 64'(dut_if.conflict_seen), 64'(0));
    check("arst_tick", 64'(dut_if.tick), 64'(0));
    set_sw(6'b000100, 1'b0);
    repeat (3) @(negedge clk);
    check("arst_held", 64'({dut_if.sw_level, dut_if.sw_pulse, dut_if.tick}), 64'(0));
    reset = 1'b1;
    e0 = edge_cnt + 1;
    push_exp(e0 + 5, 6'b000010, 1'b0);
    wait_edge(e0 + 4);
    check("requal_level_early", 64'(dut_if.sw_level), 64'(0));
    wait_edge(e0 + 5);
    check("requal_level", 64'(dut_if.sw_level), 64'(6'b000010));
    wait_edge(e0 + 12);

    check("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
